// File: rtl/timer8_capture_compare_if.sv
// timer8_capture_compare_if: register-side bus of the 8-bit timer (controls, ACK levels and status).
interface timer8_capture_compare_if #(parameter int WIDTH = 8);
  logic [2:0]       ivInputSel;
  logic [2:0]       ivInputEstimuloSel;
  logic [2:0]       ivDivSel;
  logic [WIDTH-1:0] ivCountLoad;
  logic             iTimerOverflowACK;
  logic             iInputCaptureACK;
  logic             iOutputCompareACK;
  logic [WIDTH-1:0] ivCompareValue;
  logic [WIDTH-1:0] ovCuenta;
  logic             oTimerOverflow;
  logic             oCapturaFlag;
  logic [WIDTH-1:0] ovCaptura;
  logic             oComparisonTrueFlag;
  modport master (
    output ivInputSel, ivInputEstimuloSel, ivDivSel, ivCountLoad,
           iTimerOverflowACK, iInputCaptureACK, iOutputCompareACK, ivCompareValue,
    input  ovCuenta, oTimerOverflow, oCapturaFlag, ovCaptura, oComparisonTrueFlag
  );
  modport slave (
    input  ivInputSel, ivInputEstimuloSel, ivDivSel, ivCountLoad,
           iTimerOverflowACK, iInputCaptureACK, iOutputCompareACK, ivCompareValue,
    output ovCuenta, oTimerOverflow, oCapturaFlag, ovCaptura, oComparisonTrueFlag
  );
endinterface

// File: rtl/timer8_capture_compare.sv
// timer8_capture_compare: up-counting timer with prescaler, input capture and output compare.
// Define TIMER_INPUT_SYNC_EN to add a SYNC_STAGES-flop synchronizer on iEventos / iInputCaptureEstimulo.
module timer8_capture_compare #(
  parameter int WIDTH = 8
`ifdef TIMER_INPUT_SYNC_EN
  , parameter int SYNC_STAGES = 2
`endif
) (
  input logic iClk,
  input logic iReset,
  input logic iEventos,
  input logic iInputCaptureEstimulo,
  timer8_capture_compare_if.slave bus
);
  logic evCur, capCur, evPrev, capPrev;
  logic [3:0] preCnt, preMask;
  logic evRise, evFall, capRise, capFall;
  logic preTick, countTick, capTick, atMax;
`ifdef TIMER_INPUT_SYNC_EN
  logic [SYNC_STAGES-1:0] evSync, capSync;
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) begin
      evSync <= '0;
      capSync <= '0;
    end else begin
      evSync <= SYNC_STAGES'({evSync, iEventos});
      capSync <= SYNC_STAGES'({capSync, iInputCaptureEstimulo});
    end
  assign evCur = evSync[SYNC_STAGES-1];
  assign capCur = capSync[SYNC_STAGES-1];
`else
  assign evCur = iEventos;
  assign capCur = iInputCaptureEstimulo;
`endif
  assign evRise = evCur & ~evPrev;
  assign evFall = ~evCur & evPrev;
  assign capRise = capCur & ~capPrev;
  assign capFall = ~capCur & capPrev;
  // Division ratios above /16 saturate at /16.
  always_comb begin
    preMask = bus.ivDivSel == 3'd0 ? 4'h0 :
              bus.ivDivSel == 3'd1 ? 4'h1 :
              bus.ivDivSel == 3'd2 ? 4'h3 :
              bus.ivDivSel == 3'd3 ? 4'h7 : 4'hF;
    preTick = (preCnt & preMask) == preMask;
    countTick = bus.ivInputSel == 3'd1 ? preTick :
                bus.ivInputSel == 3'd2 ? (evRise | evFall) :
                bus.ivInputSel == 3'd3 ? evFall :
                bus.ivInputSel == 3'd4 ? evRise : 1'b0;
    capTick = bus.ivInputEstimuloSel == 3'd1 ? 1'b1 :
              bus.ivInputEstimuloSel == 3'd2 ? (capRise | capFall) :
              bus.ivInputEstimuloSel == 3'd3 ? capFall :
              bus.ivInputEstimuloSel == 3'd4 ? capRise : 1'b0;
    atMax = &bus.ovCuenta;
  end
  // Every flag: a set event wins over a concurrent ACK.
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) begin
      evPrev <= 1'b0;
      capPrev <= 1'b0;
      preCnt <= 4'h0;
      bus.ovCuenta <= '0;
      bus.oTimerOverflow <= 1'b0;
      bus.ovCaptura <= '0;
      bus.oCapturaFlag <= 1'b0;
      bus.oComparisonTrueFlag <= 1'b0;
    end else begin
      evPrev <= evCur;
      capPrev <= capCur;
      preCnt <= preCnt + 4'h1;
      if (countTick) bus.ovCuenta <= atMax ? bus.ivCountLoad : bus.ovCuenta + 1'b1;
      bus.oTimerOverflow <= (countTick & atMax) | (~bus.iTimerOverflowACK & bus.oTimerOverflow);
      if (capTick) bus.ovCaptura <= bus.ovCuenta;
      bus.oCapturaFlag <= capTick | (~bus.iInputCaptureACK & bus.oCapturaFlag);
      bus.oComparisonTrueFlag <= (bus.ovCuenta >= bus.ivCompareValue) |
                                 (~bus.iOutputCompareACK & bus.oComparisonTrueFlag);
    end
endmodule

// File: tb/tb_timer8_capture_compare.sv
// tb_timer8_capture_compare: directed vector table plus hand sequences for capture, overflow, compare and reset.
module tb_timer8_capture_compare;
`ifdef TIMER_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, ev = 1'b0, capIn = 1'b0;
  int total = 0, bad = 0, expCnt = 0;
  timer8_capture_compare_if #(.WIDTH(8)) bus();
  timer8_capture_compare dut (
    .iClk(clk), .iReset(rst), .iEventos(ev), .iInputCaptureEstimulo(capIn), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] sel;
    logic [2:0] div;
    int cycles;
    int toggles;
    int delta;
  } vec_t;
  vec_t vecs[$];
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chkAllZero(input string nm);
    chk({nm, " cuenta"}, 32'(bus.ovCuenta), 0);
    chk({nm, " ovf"}, 32'(bus.oTimerOverflow), 0);
    chk({nm, " capFlag"}, 32'(bus.oCapturaFlag), 0);
    chk({nm, " captura"}, 32'(bus.ovCaptura), 0);
    chk({nm, " cmpFlag"}, 32'(bus.oComparisonTrueFlag), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    vecs.push_back('{3'd1, 3'd0, 8, 0, 8});
    vecs.push_back('{3'd1, 3'd1, 8, 0, 4});
    vecs.push_back('{3'd1, 3'd2, 16, 0, 4});
    vecs.push_back('{3'd1, 3'd3, 16, 0, 2});
    vecs.push_back('{3'd1, 3'd4, 32, 0, 2});
    vecs.push_back('{3'd1, 3'd7, 32, 0, 2});
    vecs.push_back('{3'd0, 3'd0, 16, 0, 0});
    vecs.push_back('{3'd6, 3'd1, 16, 0, 0});
    vecs.push_back('{3'd4, 3'd0, 0, 6, 3});
    vecs.push_back('{3'd3, 3'd0, 0, 6, 3});
    vecs.push_back('{3'd2, 3'd0, 0, 6, 6});
    vecs.push_back('{3'd0, 3'd0, 0, 4, 0});
    vecs.push_back('{3'd4, 3'd0, 0, 1, 1});
    vecs.push_back('{3'd4, 3'd0, 0, 1, 0});
    vecs.push_back('{3'd3, 3'd0, 0, 1, 0});
    vecs.push_back('{3'd3, 3'd0, 0, 1, 1});
    bus.ivInputSel = 3'd0;
    bus.ivInputEstimuloSel = 3'd0;
    bus.ivDivSel = 3'd0;
    bus.ivCountLoad = 8'h00;
    bus.iTimerOverflowACK = 1'b0;
    bus.iInputCaptureACK = 1'b0;
    bus.iOutputCompareACK = 1'b0;
    bus.ivCompareValue = 8'hFF;
    #3;
    chkAllZero("reset");
    tick(2);
    rst = 1'b0;
    tick(2);
    // three rising edges of iEventos with compare threshold 3
    bus.ivCompareValue = 8'd3;
    bus.ivInputSel = 3'd4;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        chk("rise cnt before 3rd", 32'(bus.ovCuenta), 2);
        chk("cmp below threshold", 32'(bus.oComparisonTrueFlag), 0);
      end
      ev = ~ev;
      tick(20);
    end
    chk("rise cnt", 32'(bus.ovCuenta), 3);
    chk("cmp at threshold", 32'(bus.oComparisonTrueFlag), 1);
    expCnt = 3;
    bus.ivInputSel = 3'd0;
    bus.ivCompareValue = 8'hFF;
    bus.iOutputCompareACK = 1'b1;
    tick(1);
    bus.iOutputCompareACK = 1'b0;
    chk("cmp ack clears", 32'(bus.oComparisonTrueFlag), 0);
    tick(2);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.ivInputSel = vecs[i].sel;
      bus.ivDivSel = vecs[i].div;
      if (vecs[i].toggles == 0) tick(vecs[i].cycles);
      else for (int t = 0; t < vecs[i].toggles; t++) begin
        ev = ~ev;
        tick(20);
      end
      bus.ivInputSel = 3'd0;
      tick(2);
      expCnt += vecs[i].delta;
      chk($sformatf("vec%0d sel%0d div%0d", i, vecs[i].sel, vecs[i].div), 32'(bus.ovCuenta), 32'(expCnt));
    end
    chk("cmp idle", 32'(bus.oComparisonTrueFlag), 0);
    // capture on rising stimulus with ACK held: one-cycle flag pulse per rise
    bus.ivInputEstimuloSel = 3'd4;
    bus.iInputCaptureACK = 1'b1;
    capIn = 1'b1;
    tick(LAT);
    chk("cap1 flag", 32'(bus.oCapturaFlag), 1);
    chk("cap1 value", 32'(bus.ovCaptura), 32'(expCnt));
    tick(1);
    chk("cap1 pulse end", 32'(bus.oCapturaFlag), 0);
    capIn = 1'b0;
    tick(4);
    bus.ivDivSel = 3'd0;
    bus.ivInputSel = 3'd1;
    capIn = 1'b1;
    tick(LAT);
    bus.ivInputSel = 3'd0;
    chk("cap2 flag", 32'(bus.oCapturaFlag), 1);
    chk("cap2 pre-increment", 32'(bus.ovCaptura), 32'(expCnt + LAT - 1));
    expCnt += LAT;
    tick(1);
    chk("cap2 pulse end", 32'(bus.oCapturaFlag), 0);
    chk("cap2 cnt", 32'(bus.ovCuenta), 32'(expCnt));
    bus.iInputCaptureACK = 1'b0;
    capIn = 1'b0;
    tick(4);
    capIn = 1'b1;
    tick(LAT + 3);
    chk("cap3 sticky", 32'(bus.oCapturaFlag), 1);
    chk("cap3 value", 32'(bus.ovCaptura), 32'(expCnt));
    bus.iInputCaptureACK = 1'b1;
    tick(1);
    bus.iInputCaptureACK = 1'b0;
    chk("cap ack clears", 32'(bus.oCapturaFlag), 0);
    bus.ivInputEstimuloSel = 3'd0;
    capIn = 1'b0;
    tick(3);
    capIn = 1'b1;
    tick(5);
    chk("cap source none", 32'(bus.oCapturaFlag), 0);
    // overflow with reload 5
    bus.ivCountLoad = 8'd5;
    bus.ivDivSel = 3'd0;
    bus.ivInputSel = 3'd1;
    tick(255 - expCnt);
    chk("ovf at max cnt", 32'(bus.ovCuenta), 32'hFF);
    chk("ovf not yet", 32'(bus.oTimerOverflow), 0);
    tick(1);
    chk("ovf reload", 32'(bus.ovCuenta), 5);
    chk("ovf set", 32'(bus.oTimerOverflow), 1);
    chk("cmp at 0xFF", 32'(bus.oComparisonTrueFlag), 1);
    tick(2);
    chk("ovf cnt after", 32'(bus.ovCuenta), 7);
    chk("ovf sticky", 32'(bus.oTimerOverflow), 1);
    bus.iTimerOverflowACK = 1'b1;
    bus.iOutputCompareACK = 1'b1;
    bus.ivInputSel = 3'd0;
    tick(1);
    bus.iOutputCompareACK = 1'b0;
    chk("ovf ack clears", 32'(bus.oTimerOverflow), 0);
    chk("cmp ack clears 2", 32'(bus.oComparisonTrueFlag), 0);
    chk("ovf paused cnt", 32'(bus.ovCuenta), 7);
    // overflow to load 0 with ACK held high: single-cycle pulse
    bus.ivCountLoad = 8'd0;
    bus.ivInputSel = 3'd1;
    tick(248);
    chk("ovf2 at max", 32'(bus.ovCuenta), 32'hFF);
    tick(1);
    chk("ovf2 load0", 32'(bus.ovCuenta), 0);
    chk("ovf2 pulse", 32'(bus.oTimerOverflow), 1);
    tick(1);
    bus.ivInputSel = 3'd0;
    chk("ovf2 pulse end", 32'(bus.oTimerOverflow), 0);
    chk("ovf2 cnt", 32'(bus.ovCuenta), 1);
    bus.iTimerOverflowACK = 1'b0;
    bus.iOutputCompareACK = 1'b1;
    tick(1);
    chk("cmp cleared", 32'(bus.oComparisonTrueFlag), 0);
    // compare value 0 is always true, beats a held ACK
    bus.ivCompareValue = 8'd0;
    tick(1);
    chk("cmp0 set", 32'(bus.oComparisonTrueFlag), 1);
    tick(3);
    chk("cmp0 held", 32'(bus.oComparisonTrueFlag), 1);
    bus.iOutputCompareACK = 1'b0;
    // asynchronous reset mid-count
    bus.ivInputSel = 3'd1;
    tick(3);
    chk("pre-reset cnt", 32'(bus.ovCuenta), 4);
    #2;
    rst = 1'b1;
    #1;
    chkAllZero("midreset");
    tick(2);
    rst = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
